// File: rtl/banco_registradores.sv
// banco_registradores: 32-entry register file, two forwarding read ports, saturating write counter
module banco_registradores #(
  parameter int LARGURA = 32,
  parameter logic [LARGURA-1:0] SP_INICIAL = 32'h0000_03FC
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [4:0]         reg_leitura1,
  input  logic [4:0]         reg_leitura2,
  input  logic [4:0]         escrita_registrador,
  input  logic [LARGURA-1:0] dado_escrita,
  input  logic               escreve_reg,
  output logic [LARGURA-1:0] dado_leitura1,
  output logic [LARGURA-1:0] dado_leitura2,
  output logic [15:0]        total_escritas
);
  logic [LARGURA-1:0] regs [32];
  logic we;
  // A write commits only with a definite 1 on the enable, a nonzero target and reset released
  always_comb we = (escreve_reg === 1'b1) && (escrita_registrador != 5'd0) && reset;
  // Register array: async reset restores $sp, otherwise store the committed write
  always_ff @(posedge clock or negedge reset)
    if (!reset)
      for (int i = 0; i < 32; i++) regs[i] <= (i == 29) ? SP_INICIAL : '0;
    else if (we)
      regs[escrita_registrador] <= dado_escrita;
  // Count committed writes, holding at all-ones
  always_ff @(posedge clock or negedge reset)
    if (!reset) total_escritas <= '0;
    else if (we && total_escritas != 16'hFFFF) total_escritas <= total_escritas + 16'd1;
  // Combinational reads with same-cycle write forwarding; address 0 always reads zero
  always_comb begin
    dado_leitura1 = (reg_leitura1 == 5'd0) ? '0 :
                    (we && escrita_registrador == reg_leitura1) ? dado_escrita : regs[reg_leitura1];
    dado_leitura2 = (reg_leitura2 == 5'd0) ? '0 :
                    (we && escrita_registrador == reg_leitura2) ? dado_escrita : regs[reg_leitura2];
  end
endmodule
